// File: rtl/saph_fpu_arbiter.sv
// Round-robin arbiter that shares one fixed-latency FPU between N requesters.
// A tag pipeline tracks each issued operation and routes its result back to the issuer.
module saph_fpu_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned MW    = 4,
  parameter int unsigned MODES = 16,
  parameter int unsigned LAT   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  input  logic [N*MW-1:0]     req_mode,
  input  logic [N*W-1:0]      req_opa,
  input  logic [N*W-1:0]      req_opb,
  output logic [N-1:0]        req_ready,
  output logic                fpu_valid,
  output logic [MW-1:0]       fpu_mode,
  output logic [W-1:0]        fpu_opa,
  output logic [W-1:0]        fpu_opb,
  input  logic                fpu_ready,
  input  logic [MODES-1:0]    fpu_has_modes,
  input  logic                fpu_res_valid,
  input  logic [W-1:0]        fpu_res,
  output logic [N-1:0]        rsp_valid,
  output logic [W-1:0]        rsp_res,
  output logic                busy,
  output logic                err
);

  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

  logic [IDW-1:0]          r_ptr;
  logic [LAT-1:0]          r_tag_v;
  logic [LAT-1:0][IDW-1:0] r_tag_id;
  logic [N-1:0]            r_rsp_valid;
  logic [W-1:0]            r_rsp_res;
  logic                    r_err;

  logic [N-1:0]            w_elig;
  logic                    w_any;
  logic                    w_fire;
  logic [IDW-1:0]          w_gnt;
  logic [IDW-1:0]          w_cand;
  logic                    w_tail_v;
  logic [IDW-1:0]          w_tail_id;
  logic                    w_tail_hit;
  logic [N-1:0]            w_tail_onehot;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_elig[i] = req_valid[i] & fpu_has_modes[req_mode[i*MW +: MW]];
    end
  end

  // Walk the requesters starting at r_ptr; the first eligible one wins.
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = '0;
    w_cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IDW'((32'(r_ptr) + k) % N);
      if (!w_any && w_elig[w_cand]) begin
        w_any = 1'b1;
        w_gnt = w_cand;
      end
    end
  end

  assign w_fire = w_any & fpu_ready;

  always_comb begin
    req_ready = '0;
    fpu_valid = w_fire;
    fpu_mode  = '0;
    fpu_opa   = '0;
    fpu_opb   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_any && (w_gnt == IDW'(i))) begin
        fpu_mode     = req_mode[i*MW +: MW];
        fpu_opa      = req_opa[i*W +: W];
        fpu_opb      = req_opb[i*W +: W];
        req_ready[i] = w_fire;
      end
    end
  end

  assign w_tail_v   = r_tag_v[LAT-1];
  assign w_tail_id  = r_tag_id[LAT-1];
  assign w_tail_hit = w_tail_v & fpu_res_valid;

  always_comb begin
    w_tail_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_tail_id == IDW'(i)) w_tail_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_tag_v     <= '0;
      r_tag_id    <= '0;
      r_rsp_valid <= '0;
      r_rsp_res   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_fire) r_ptr <= (w_gnt == IDW'(N-1)) ? '0 : w_gnt + 1'b1;
      r_tag_v[0]  <= w_fire;
      r_tag_id[0] <= w_gnt;
      for (int unsigned s = 1; s < LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
      r_rsp_valid <= w_tail_hit ? w_tail_onehot : '0;
      if (w_tail_hit) r_rsp_res <= fpu_res;
      // A missing or stray result both latch the sticky error.
      if (w_tail_v != fpu_res_valid) r_err <= 1'b1;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_res   = r_rsp_res;
  assign err       = r_err;
  assign busy      = |r_tag_v;

endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// Self-checking bench for saph_fpu_arbiter: the bench plays the FPU and compares
// every cycle against a history-based reference model of arbitration and responses.
module tb_saph_fpu_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int MW    = 4;
  localparam int MODES = 16;
  localparam int LAT   = 3;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*MW-1:0]   req_mode;
  logic [N*W-1:0]    req_opa;
  logic [N*W-1:0]    req_opb;
  logic [N-1:0]      req_ready;
  logic              fpu_valid;
  logic [MW-1:0]     fpu_mode;
  logic [W-1:0]      fpu_opa;
  logic [W-1:0]      fpu_opb;
  logic              fpu_ready;
  logic [MODES-1:0]  fpu_has_modes;
  logic              fpu_res_valid;
  logic [W-1:0]      fpu_res;
  logic [N-1:0]      rsp_valid;
  logic [W-1:0]      rsp_res;
  logic              busy;
  logic              err;

  saph_fpu_arbiter #(.N(N), .W(W), .MW(MW), .MODES(MODES), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_mode(req_mode), .req_opa(req_opa), .req_opb(req_opb),
    .req_ready(req_ready),
    .fpu_valid(fpu_valid), .fpu_mode(fpu_mode), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
    .fpu_ready(fpu_ready), .fpu_has_modes(fpu_has_modes),
    .fpu_res_valid(fpu_res_valid), .fpu_res(fpu_res),
    .rsp_valid(rsp_valid), .rsp_res(rsp_res), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    int          id;
    logic [W-1:0] res;
  } issue_t;

  // Issues of the last LAT cycles, oldest first; the FPU answers the oldest one.
  issue_t       hist[$];
  int           m_ptr;
  logic [N-1:0] m_rsp_valid;
  logic [W-1:0] m_rsp_res;
  logic         m_err;

  int           tests;
  int           fails;
  logic [N-1:0] obs_ready;
  logic         obs_fvalid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] e, input int ptr);
    int best;
    int bestd;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (e[i]) begin
        int d;
        d = (i - ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic set_lane(input int i, input logic v, input logic [MW-1:0] m,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]         = v;
    req_mode[i*MW +: MW] = m;
    req_opa[i*W +: W]    = a;
    req_opb[i*W +: W]    = b;
  endtask

  task automatic set_all(input logic v);
    for (int i = 0; i < N; i++)
      set_lane(i, v, MW'($urandom_range(0, MODES-1)), $urandom(), $urandom());
  endtask

  task automatic model_reset();
    hist.delete();
    m_ptr       = 0;
    m_rsp_valid = '0;
    m_rsp_res   = '0;
    m_err       = 1'b0;
  endtask

  // Asynchronous reset asserted away from any clock edge and checked at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    fpu_res_valid = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rsp_res", 32'(rsp_res), 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cycle(input bit drop, input bit stray);
    issue_t       t;
    logic [N-1:0] elig;
    logic [N-1:0] one;
    logic [N-1:0] exp_ready;
    logic [MW-1:0] em;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    int           g;
    bit           fire;
    bit           ebusy;
    t = '{v: 1'b0, id: 0, res: '0};
    if (hist.size() >= LAT) t = hist[hist.size()-LAT];
    fpu_res_valid = (t.v && !drop) || stray;
    fpu_res       = t.v ? t.res : $urandom();
    #1;
    for (int i = 0; i < N; i++)
      elig[i] = req_valid[i] && fpu_has_modes[req_mode[i*MW +: MW]];
    g    = pick(elig, m_ptr);
    fire = (g >= 0) && fpu_ready;
    one  = 1;
    exp_ready = fire ? (one << g) : '0;
    em = '0; ea = '0; eb = '0;
    if (g >= 0) begin
      em = req_mode[g*MW +: MW];
      ea = req_opa[g*W +: W];
      eb = req_opb[g*W +: W];
    end
    ebusy = 1'b0;
    foreach (hist[k]) if (hist[k].v) ebusy = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("fpu_valid", 32'(fpu_valid), 32'(fire));
    chk("fpu_mode", 32'(fpu_mode), 32'(em));
    chk("fpu_opa", fpu_opa, ea);
    chk("fpu_opb", fpu_opb, eb);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    chk("rsp_res", rsp_res, m_rsp_res);
    chk("err", 32'(err), 32'(m_err));
    chk("busy", 32'(busy), 32'(ebusy));
    obs_ready  = req_ready;
    obs_fvalid = fpu_valid;
    if (t.v && fpu_res_valid) begin
      m_rsp_valid = one << t.id;
      m_rsp_res   = fpu_res;
    end else begin
      m_rsp_valid = '0;
    end
    if (t.v != fpu_res_valid) m_err = 1'b1;
    hist.push_back('{v: fire, id: (g < 0) ? 0 : g, res: ea + eb});
    while (hist.size() > LAT) void'(hist.pop_front());
    if (fire) m_ptr = (g + 1) % N;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] seq;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req_valid = '0; req_mode = '0; req_opa = '0; req_opb = '0;
    fpu_ready = 1'b1;
    fpu_has_modes = '1;
    fpu_res_valid = 1'b0;
    fpu_res = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single request, result 0x3F800000 arrives after LAT cycles.
    set_lane(0, 1'b1, 4'd1, 32'h3F80_0000, 32'h0);
    cycle(0, 0);
    chk("t1_grant", 32'(obs_ready), 32'h1);
    set_all(1'b0);
    repeat (3) cycle(0, 0);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_res", rsp_res, 32'h3F80_0000);
    chk("t1_err", 32'(err), 32'd0);
    cycle(0, 0);

    // All requesters continuously valid: strict rotation starting at req0.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_all(1'b1);
      cycle(0, 0);
      seq = 1;
      seq = seq << (k % N);
      chk("t2_rotation", 32'(obs_ready), 32'(seq));
    end
    set_all(1'b0);

    // Grant req1, stall the FPU for 5 cycles with req2/req3 pending.
    set_lane(1, 1'b1, 4'd3, $urandom(), $urandom());
    cycle(0, 0);
    chk("t3_grant1", 32'(obs_ready), 32'h2);
    set_all(1'b0);
    set_lane(2, 1'b1, 4'd2, $urandom(), $urandom());
    set_lane(3, 1'b1, 4'd7, $urandom(), $urandom());
    fpu_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0);
      chk("t3_stall_ready", 32'(obs_ready), 32'd0);
      chk("t3_stall_fvalid", 32'(obs_fvalid), 32'd0);
    end
    fpu_ready = 1'b1;
    cycle(0, 0);
    chk("t3_release", 32'(obs_ready), 32'h4);
    set_all(1'b0);

    // Unsupported mode on req1 never blocks req2.
    fpu_has_modes = 16'hFFDF;
    for (int k = 0; k < 4; k++) begin
      set_lane(1, 1'b1, 4'd5, $urandom(), $urandom());
      set_lane(2, 1'b1, 4'd2, $urandom(), $urandom());
      cycle(0, 0);
      chk("t4_only_req2", 32'(obs_ready), 32'h4);
    end
    set_all(1'b0);
    fpu_has_modes = '1;
    repeat (LAT + 1) cycle(0, 0);

    // Missing result, then a stray result on an empty pipeline.
    do_reset();
    set_lane(0, 1'b1, 4'd1, $urandom(), $urandom());
    cycle(0, 0);
    set_all(1'b0);
    cycle(0, 0);
    cycle(0, 0);
    cycle(1, 0);
    chk("t5_missing_err", 32'(err), 32'd1);
    chk("t5_missing_rsp", 32'(rsp_valid), 32'd0);
    cycle(0, 0);
    chk("t5_sticky", 32'(err), 32'd1);
    do_reset();
    cycle(0, 1);
    chk("t5_stray_err", 32'(err), 32'd1);
    do_reset();

    // Random traffic with random FPU back-pressure and mode support.
    fpu_has_modes = MODES'($urandom()) | MODES'(16'h00FF);
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++)
        set_lane(i, 1'($urandom_range(0, 9) < 7), MW'($urandom_range(0, MODES-1)),
                 $urandom(), $urandom());
      fpu_ready = 1'($urandom_range(0, 9) < 8);
      if (k % 50 == 49) fpu_has_modes = MODES'($urandom()) | MODES'(16'h000F);
      cycle(0, 0);
    end
    fpu_has_modes = '1;
    fpu_ready = 1'b1;

    // Reset with three operations in flight.
    set_all(1'b1);
    repeat (3) begin
      cycle(0, 0);
      set_all(1'b1);
    end
    chk("t6_busy_before", 32'(busy), 32'd1);
    do_reset();
    set_all(1'b1);
    cycle(0, 0);
    chk("t6_first_grant", 32'(obs_ready), 32'h1);
    set_all(1'b0);
    repeat (LAT + 2) cycle(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
